// File: rtl/eth_ping_rx.sv
// Broadcast probe-frame receiver: extracts a per-channel ping sequence number from an 8-bit AXI-Stream.
// Defining ETH_PING_RX_LOSS_CNT_EN adds per-channel lost / out-of-order ping accounting.
module eth_ping_rx #(
    parameter logic [47:0] SRC_MAC    = 48'h0,
    parameter logic [15:0] ETHERTYPE  = 16'h0000,
    parameter logic [23:0] IDENTIFIER = 24'h0,
    parameter int          NUM_CH     = 4,
    parameter int          ID_BYTES   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     s_axis_tdata,
    input  logic                           s_axis_tkeep,
    input  logic                           s_axis_tuser,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tvalid,
    output logic [NUM_CH*8*ID_BYTES-1:0]   ping_id,
    output logic [NUM_CH-1:0]              ping_valid,
    output logic [NUM_CH*32-1:0]           loss_count,
    output logic [NUM_CH*16-1:0]           ooo_count
);

    localparam int ID_WIDTH = 8 * ID_BYTES;
    localparam int HDR_LEN  = 18 + ID_BYTES;
    localparam int CAP_W    = 8 * HDR_LEN;

    logic             beat_acc;
    logic             frame_end;
    logic [15:0]      count_q, count_d;
    logic [CAP_W-1:0] cap_q, cap_d;
    logic [CAP_W-1:0] cap_upd;
    logic [16:0]      len_eff;

    logic [47:0]         f_dst;
    logic [47:0]         f_src;
    logic [15:0]         f_etype;
    logic [23:0]         f_ident;
    logic [7:0]          f_chan;
    logic [ID_WIDTH-1:0] f_id;
    logic                frame_ok;
    logic [NUM_CH-1:0]   hit;

    assign beat_acc  = s_axis_tvalid & s_axis_tkeep;
    assign frame_end = s_axis_tvalid & s_axis_tlast;

    always_comb begin
        count_d = count_q;
        if (frame_end) begin
            count_d = '0;
        end else if (beat_acc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // The tlast byte itself may complete the header, so fields are decoded from the
    // capture value that already includes the current beat.
    always_comb begin
        cap_upd = cap_q;
        if (beat_acc && (count_q < 16'(HDR_LEN))) begin
            cap_upd = {cap_q[CAP_W-9:0], s_axis_tdata};
        end
        cap_d = frame_end ? '0 : cap_upd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            cap_q   <= '0;
        end else begin
            count_q <= count_d;
            cap_q   <= cap_d;
        end
    end

    // Accepted length includes the tlast beat only when that beat carries a byte.
    assign len_eff = {1'b0, count_q} + {16'd0, beat_acc};

    assign f_dst   = cap_upd[CAP_W-1   -: 48];
    assign f_src   = cap_upd[CAP_W-49  -: 48];
    assign f_etype = cap_upd[CAP_W-97  -: 16];
    assign f_ident = cap_upd[CAP_W-113 -: 24];
    assign f_chan  = cap_upd[CAP_W-137 -: 8];
    assign f_id    = cap_upd[ID_WIDTH-1:0];

    assign frame_ok = frame_end
                    && !s_axis_tuser
                    && (len_eff >= 17'(HDR_LEN))
                    && (f_dst == 48'hFFFF_FFFF_FFFF)
                    && (f_src == SRC_MAC)
                    && (f_etype == ETHERTYPE)
                    && (f_ident == IDENTIFIER)
                    && (f_chan < 8'(NUM_CH));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [ID_WIDTH-1:0] id_q, id_d;
            logic                valid_q, valid_d;

            assign hit[gi] = frame_ok && (f_chan == 8'(gi));

            always_comb begin
                id_d    = id_q;
                valid_d = hit[gi];
                if (hit[gi]) begin
                    id_d = f_id;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    id_q    <= '1;
                    valid_q <= 1'b0;
                end else begin
                    id_q    <= id_d;
                    valid_q <= valid_d;
                end
            end

            assign ping_id[gi*ID_WIDTH +: ID_WIDTH] = id_q;
            assign ping_valid[gi]                   = valid_q;

`ifdef ETH_PING_RX_LOSS_CNT_EN
            logic                seen_q, seen_d;
            logic [31:0]         loss_q, loss_d;
            logic [15:0]         ooo_q, ooo_d;
            logic [ID_WIDTH-1:0] gap;
            logic                in_seq;
            logic [64:0]         loss_sum;

            // Modular gap; the upper half of the ID space is read as "went backwards".
            assign gap      = f_id - id_q - ID_WIDTH'(1);
            assign in_seq   = !gap[ID_WIDTH-1];
            assign loss_sum = {33'd0, loss_q} + 65'(gap);

            always_comb begin
                seen_d = seen_q;
                loss_d = loss_q;
                ooo_d  = ooo_q;
                if (hit[gi]) begin
                    seen_d = 1'b1;
                    if (seen_q) begin
                        if (in_seq) begin
                            loss_d = (loss_sum > 65'hFFFF_FFFF) ? 32'hFFFF_FFFF : loss_sum[31:0];
                        end else if (ooo_q != 16'hFFFF) begin
                            ooo_d = ooo_q + 16'd1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    seen_q <= 1'b0;
                    loss_q <= '0;
                    ooo_q  <= '0;
                end else begin
                    seen_q <= seen_d;
                    loss_q <= loss_d;
                    ooo_q  <= ooo_d;
                end
            end

            assign loss_count[gi*32 +: 32] = loss_q;
            assign ooo_count[gi*16 +: 16]  = ooo_q;
`else
            assign loss_count[gi*32 +: 32] = '0;
            assign ooo_count[gi*16 +: 16]  = '0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_eth_ping_rx.sv
// Scoreboarded bench for eth_ping_rx: a frame-level reference model queues expected updates,
// an independent monitor checks every ping_valid strobe against them.
module tb_eth_ping_rx;

    localparam int NUM_CH   = 4;
    localparam int ID_BYTES = 4;
    localparam int IDW      = 8 * ID_BYTES;
    localparam int HDR_LEN  = 18 + ID_BYTES;
    localparam logic [47:0] SRC   = 48'h0200_1122_3344;
    localparam logic [15:0] ETYPE = 16'h88B5;
    localparam logic [23:0] IDENT = 24'hABCDEF;

    typedef byte unsigned bq_t[$];

    typedef struct {
        logic [NUM_CH-1:0]     vld;
        logic [NUM_CH*IDW-1:0] ids;
        logic [NUM_CH*32-1:0]  loss;
        logic [NUM_CH*16-1:0]  ooo;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [7:0]            s_axis_tdata = '0;
    logic                  s_axis_tkeep = 1'b0;
    logic                  s_axis_tuser = 1'b0;
    logic                  s_axis_tlast = 1'b0;
    logic                  s_axis_tvalid = 1'b0;
    logic [NUM_CH*IDW-1:0] ping_id;
    logic [NUM_CH-1:0]     ping_valid;
    logic [NUM_CH*32-1:0]  loss_count;
    logic [NUM_CH*16-1:0]  ooo_count;

    int tests = 0;
    int fails = 0;

    exp_t            exp_q[$];
    logic [IDW-1:0]  m_id[NUM_CH];
    bit              m_seen[NUM_CH];
    longint unsigned m_loss[NUM_CH];
    int              m_ooo[NUM_CH];

    eth_ping_rx #(
        .SRC_MAC(SRC), .ETHERTYPE(ETYPE), .IDENTIFIER(IDENT),
        .NUM_CH(NUM_CH), .ID_BYTES(ID_BYTES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .ping_id(ping_id), .ping_valid(ping_valid),
        .loss_count(loss_count), .ooo_count(ooo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ping_valid !== '0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got %0h expected 0", ping_valid);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ping_valid", 128'(ping_valid), 128'(e.vld));
                chk("ping_id", 128'(ping_id), 128'(e.ids));
                chk("loss_count", 128'(loss_count), 128'(e.loss));
                chk("ooo_count", 128'(ooo_count), 128'(e.ooo));
            end
        end
    end

    function automatic bq_t mk(input int ch, input logic [IDW-1:0] id, input int extra);
        bq_t q;
        logic [47:0] s = SRC;
        logic [15:0] e = ETYPE;
        logic [23:0] t = IDENT;
        logic [IDW-1:0] v = id;
        repeat (6) q.push_back(8'hFF);
        for (int i = 0; i < 6; i++) begin q.push_back(s[47:40]); s = s << 8; end
        for (int i = 0; i < 2; i++) begin q.push_back(e[15:8]); e = e << 8; end
        for (int i = 0; i < 3; i++) begin q.push_back(t[23:16]); t = t << 8; end
        q.push_back(8'(ch));
        for (int i = 0; i < ID_BYTES; i++) begin q.push_back(v[IDW-1 -: 8]); v = v << 8; end
        for (int i = 0; i < extra; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic bit frame_good(input bq_t fr, input bit tuser);
        bq_t tpl = mk(0, '0, 0);
        if (tuser || fr.size() < HDR_LEN) return 1'b0;
        for (int i = 0; i < 17; i++) if (fr[i] != tpl[i]) return 1'b0;
        return fr[17] < NUM_CH;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_id[c] = '1; m_seen[c] = 1'b0; m_loss[c] = 0; m_ooo[c] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_accept(input bq_t fr);
        exp_t e;
        int ch = int'(fr[17]);
        logic [IDW-1:0] id = '0;
        for (int i = 0; i < ID_BYTES; i++) id = (id << 8) | IDW'(fr[18+i]);
`ifdef ETH_PING_RX_LOSS_CNT_EN
        if (m_seen[ch]) begin
            logic [IDW-1:0] d = id - m_id[ch] - 1;
            if (d < (IDW'(1) << (IDW-1))) begin
                m_loss[ch] = m_loss[ch] + longint'(d);
                if (m_loss[ch] > 64'hFFFF_FFFF) m_loss[ch] = 64'hFFFF_FFFF;
            end else if (m_ooo[ch] < 65535) begin
                m_ooo[ch]++;
            end
        end
`endif
        m_seen[ch] = 1'b1;
        m_id[ch] = id;
        e.vld = '0;
        e.vld[ch] = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            e.ids[c*IDW +: IDW] = m_id[c];
            e.loss[c*32 +: 32]  = m_loss[c][31:0];
            e.ooo[c*16 +: 16]   = 16'(m_ooo[c]);
        end
        exp_q.push_back(e);
    endtask

    task automatic beat(input logic [7:0] d, input logic k, input logic l, input logic u);
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send(input bq_t fr, input bit tuser, input int keep0_pct, input bit empty_last, input int idle);
        bit good = frame_good(fr, tuser);
        $display("[TB] frame len=%0d ch=%0d tuser=%0d keep0=%0d emptylast=%0d good=%0d",
                 fr.size(), (fr.size() > 17) ? int'(fr[17]) : -1, tuser, keep0_pct, empty_last, good);
        for (int i = 0; i < fr.size(); i++) begin
            bit last = (i == fr.size() - 1) && !empty_last;
            while (keep0_pct > 0 && $urandom_range(99) < keep0_pct) beat(8'($urandom), 1'b0, 1'b0, 1'b0);
            if (last && good) model_accept(fr);
            beat(fr[i], 1'b1, last, last ? tuser : 1'b0);
        end
        if (empty_last) begin
            if (good) model_accept(fr);
            beat(8'($urandom), 1'b0, 1'b1, tuser);
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tkeep = 1'b0; s_axis_tuser = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ping_id"}, 128'(ping_id), {128{1'b1}});
        chk({tag, "_ping_valid"}, 128'(ping_valid), 128'd0);
        chk({tag, "_loss"}, 128'(loss_count), 128'd0);
        chk({tag, "_ooo"}, 128'(ooo_count), 128'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tkeep = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_state(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        bq_t fr;
        model_reset();
        do_reset("reset");

        // Directed: valid ch2 frame of exactly HDR_LEN bytes.
        send(mk(2, 32'd5, 0), 1'b0, 0, 1'b0, 3);
        // Drops: src MAC bit error, bad FCS, one byte short, channel out of range.
        fr = mk(2, 32'd6, 3); fr[11] = fr[11] ^ 8'h01;
        send(fr, 1'b0, 0, 1'b0, 2);
        send(mk(2, 32'd7, 3), 1'b1, 0, 1'b0, 2);
        fr = mk(2, 32'd8, 0); void'(fr.pop_back());
        send(fr, 1'b0, 0, 1'b0, 2);
        send(mk(7, 32'd9, 2), 1'b0, 0, 1'b0, 2);
        chk("drops_ch2_id", 128'(ping_id[2*IDW +: IDW]), 128'd5);
        // Back-to-back frames with zero idle cycles.
        send(mk(0, 32'h100, 1), 1'b0, 0, 1'b0, 0);
        send(mk(1, 32'h200, 0), 1'b0, 0, 1'b0, 3);

        // Sequence tracking from a clean state.
        do_reset("reset2");
        send(mk(0, 32'd10, 0), 1'b0, 0, 1'b0, 1);
        send(mk(0, 32'd11, 0), 1'b0, 0, 1'b0, 1);
        send(mk(0, 32'd15, 0), 1'b0, 0, 1'b0, 1);
        send(mk(0, 32'd12, 0), 1'b0, 0, 1'b0, 1);
        send(mk(3, 32'hFFFF_FFFF, 0), 1'b0, 0, 1'b0, 0);
        send(mk(3, 32'h0, 0), 1'b0, 0, 1'b0, 3);
        chk("seq_ch0_id", 128'(ping_id[IDW-1:0]), 128'd12);
`ifdef ETH_PING_RX_LOSS_CNT_EN
        chk("seq_ch0_loss", 128'(loss_count[31:0]), 128'd3);
        chk("seq_ch0_ooo", 128'(ooo_count[15:0]), 128'd1);
`else
        chk("seq_ch0_loss", 128'(loss_count[31:0]), 128'd0);
        chk("seq_ch0_ooo", 128'(ooo_count[15:0]), 128'd0);
`endif
        chk("wrap_ch3_loss", 128'(loss_count[3*32 +: 32]), 128'd0);

        // Reset in the middle of a valid frame, then a clean frame.
        fr = mk(1, 32'd77, 0);
        for (int i = 0; i < 10; i++) beat(fr[i], 1'b1, 1'b0, 1'b0);
        do_reset("midrst");
        send(mk(1, 32'd9, 0), 1'b0, 0, 1'b0, 2);

        // tkeep=0 bubbles inside a frame and an empty tlast beat.
        send(mk(1, 32'hDEAD_BEEF, 2), 1'b0, 30, 1'b0, 2);
        send(mk(2, 32'hCAFE_0001, 0), 1'b0, 20, 1'b1, 2);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int ch = $urandom_range(5);
            int mode = $urandom_range(9);
            int csel = (ch < NUM_CH) ? ch : 0;
            logic [IDW-1:0] id;
            bit tu = 1'b0;
            bit el;
            case ($urandom_range(3))
                0, 1: id = m_id[csel] + IDW'($urandom_range(1, 4));
                2:    id = m_id[csel] - IDW'($urandom_range(0, 3));
                default: id = IDW'($urandom);
            endcase
            fr = mk(ch, id, $urandom_range(4));
            if (mode == 0) begin
                int p = $urandom_range(17);
                fr[p] = fr[p] ^ (8'h01 << $urandom_range(7));
            end else if (mode == 1) begin
                int keep = $urandom_range(1, HDR_LEN);
                while (fr.size() > keep) void'(fr.pop_back());
            end else if (mode == 2) begin
                tu = 1'b1;
            end
            el = ($urandom_range(4) == 0) && (fr.size() != HDR_LEN - 1);
            send(fr, tu, $urandom_range(1) ? 15 : 0, el, $urandom_range(2));
        end

        repeat (6) begin @(posedge clk); #1; end
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
